// File: rtl/rv32i_types.sv
// Shared RV32I encodings, raw instruction views and the decoded micro-op
// carried from the decode stage to rename/dispatch.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  // Encoded as {funct7[5], funct3} so register/immediate ops map straight through.
  typedef enum logic [3:0] {
    alu_op_add  = 4'b0000,
    alu_op_sll  = 4'b0001,
    alu_op_slt  = 4'b0010,
    alu_op_sltu = 4'b0011,
    alu_op_xor  = 4'b0100,
    alu_op_srl  = 4'b0101,
    alu_op_or   = 4'b0110,
    alu_op_and  = 4'b0111,
    alu_op_sub  = 4'b1000,
    alu_op_sra  = 4'b1101
  } alu_op_type;

  typedef enum logic [2:0] {
    imm_fmt_i, imm_fmt_s, imm_fmt_b, imm_fmt_u, imm_fmt_j, imm_fmt_r
  } imm_fmt_t;

  localparam logic [2:0] funct3_add     = 3'b000;
  localparam logic [2:0] funct3_sll     = 3'b001;
  localparam logic [2:0] funct3_sr      = 3'b101;
  localparam logic [6:0] funct7_base    = 7'b0000000;
  localparam logic [6:0] funct7_variant = 7'b0100000;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_type_t;

  typedef struct packed {
    logic [11:0] i_imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;

  typedef struct packed {
    logic [6:0] imm_hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_lo;
    logic [6:0] opcode;
  } s_type_t;

  typedef struct packed {
    logic       imm_12;
    logic [5:0] imm_10_5;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [3:0] imm_4_1;
    logic       imm_11;
    logic [6:0] opcode;
  } b_type_t;

  typedef struct packed {
    logic [19:0] u_imm;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } u_type_t;

  typedef struct packed {
    logic       imm_20;
    logic [9:0] imm_10_1;
    logic       imm_11;
    logic [7:0] imm_19_12;
    logic [4:0] rd;
    logic [6:0] opcode;
  } j_type_t;

  typedef union packed {
    logic [31:0] word;
    r_type_t     r_type;
    i_type_t     i_type;
    s_type_t     s_type;
    b_type_t     b_type;
    u_type_t     u_type;
    j_type_t     j_type;
  } instr_t;

  typedef struct packed {
    logic [31:0] pc;
    rv32i_opcode opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    alu_op_type  alu_op;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        illegal;
  } decoded_uop_t;

  // The B-type offset is scattered across four fields; reassemble and sign-extend.
  function automatic logic [31:0] b_imm(input b_type_t b);
    return {{20{b.imm_12}}, b.imm_11, b.imm_10_5, b.imm_4_1, 1'b0};
  endfunction

endpackage

// File: rtl/rv32i_decode_comb.sv
// Purely combinational RV32I decoder: raw instruction word plus PC in,
// fully decoded micro-op out.
module rv32i_decode_comb
  import rv32i_types::*;
(
  input  instr_t       instr,
  input  logic [31:0]  pc,
  output decoded_uop_t uop
);

  imm_fmt_t    fmt;
  alu_op_type  alu_op;
  logic        uses_rs1, uses_rs2, writes_rd, illegal;
  logic [31:0] imm;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        rs1_en, rs2_en, rd_en;

  assign funct3 = instr.r_type.funct3;
  assign funct7 = instr.r_type.funct7;

  always_comb begin
    fmt       = imm_fmt_r;
    alu_op    = alu_op_add;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (instr.r_type.opcode)
      op_lui, op_auipc: begin
        fmt       = imm_fmt_u;
        writes_rd = 1'b1;
      end
      op_jal: begin
        fmt       = imm_fmt_j;
        writes_rd = 1'b1;
      end
      op_jalr: begin
        fmt       = imm_fmt_i;
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        illegal   = (funct3 != 3'b000);
      end
      op_br: begin
        fmt      = imm_fmt_b;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        illegal  = (funct3[2:1] == 2'b01);
      end
      op_load: begin
        fmt       = imm_fmt_i;
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        illegal   = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      op_store: begin
        fmt      = imm_fmt_s;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        illegal  = (funct3 > 3'b010);
      end
      op_imm: begin
        fmt       = imm_fmt_i;
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        // Only the right shift uses funct7[5] to pick arithmetic vs logical.
        alu_op    = alu_op_type'({(funct3 == funct3_sr) & funct7[5], funct3});
        if (funct3 == funct3_sll)
          illegal = (funct7 != funct7_base);
        else if (funct3 == funct3_sr)
          illegal = (funct7 != funct7_base) && (funct7 != funct7_variant);
      end
      op_reg: begin
        fmt       = imm_fmt_r;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
        alu_op    = alu_op_type'({funct7[5], funct3});
        illegal   = !((funct7 == funct7_base) ||
                      ((funct7 == funct7_variant) &&
                       ((funct3 == funct3_add) || (funct3 == funct3_sr))));
      end
      default: illegal = 1'b1;
    endcase
    if (instr.r_type.opcode[1:0] != 2'b11)
      illegal = 1'b1;
  end

  always_comb begin
    imm = '0;
    case (fmt)
      imm_fmt_i: imm = {{20{instr.i_type.i_imm[11]}}, instr.i_type.i_imm};
      imm_fmt_s: imm = {{20{instr.s_type.imm_hi[6]}}, instr.s_type.imm_hi, instr.s_type.imm_lo};
      imm_fmt_b: imm = b_imm(instr.b_type);
      imm_fmt_u: imm = {instr.u_type.u_imm, 12'b0};
      imm_fmt_j: imm = {{12{instr.j_type.imm_20}}, instr.j_type.imm_19_12,
                        instr.j_type.imm_11, instr.j_type.imm_10_1, 1'b0};
      default:   imm = '0;
    endcase
  end

  // Illegal uops keep their raw fields but claim no registers.
  assign rs1_en = uses_rs1 & ~illegal;
  assign rs2_en = uses_rs2 & ~illegal;
  assign rd_en  = writes_rd & ~illegal & (instr.r_type.rd != 5'd0);

  always_comb begin
    uop           = '0;
    uop.pc        = pc;
    uop.opcode    = rv32i_opcode'(instr.r_type.opcode);
    uop.funct3    = funct3;
    uop.rd        = rd_en  ? instr.r_type.rd  : 5'd0;
    uop.rs1       = rs1_en ? instr.r_type.rs1 : 5'd0;
    uop.rs2       = rs2_en ? instr.r_type.rs2 : 5'd0;
    uop.imm       = imm;
    uop.alu_op    = alu_op;
    uop.uses_rs1  = rs1_en;
    uop.uses_rs2  = rs2_en;
    uop.writes_rd = rd_en;
    uop.illegal   = illegal;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32I decode stage with a two-entry skid buffer (main M drives
// the outputs, skid S absorbs one extra uop) so in_ready is a plain flop.
module instr_decode_stage
  import rv32i_types::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  instr_t          in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output decoded_uop_t    out_uop
);

  // Handshake: a transfer happens on a rising edge where valid && ready; a
  // producer holds valid and its payload until that edge, and valid never
  // depends combinationally on ready on either side of this stage.

  decoded_uop_t dec_uop, m_uop, s_uop;
  logic         m_valid, s_valid, in_ready_q;
  logic         m_valid_n, s_valid_n;
  logic         m_load_dec, m_load_s, s_load;
  logic         accept, drain;
  logic [31:0]  pc_ext;

  // The uop carries a 32-bit pc; narrower PCs are zero-extended.
  assign pc_ext = 32'(in_pc);

  rv32i_decode_comb u_decode (
    .instr (in_instr),
    .pc    (pc_ext),
    .uop   (dec_uop)
  );

  assign accept = in_valid & in_ready_q;
  assign drain  = m_valid & out_ready;

  always_comb begin
    m_valid_n  = m_valid;
    s_valid_n  = s_valid;
    m_load_dec = 1'b0;
    m_load_s   = 1'b0;
    s_load     = 1'b0;
    if (!m_valid || drain) begin
      // in_ready is low whenever S holds data, so S and a new accept never collide.
      if (s_valid) begin
        m_load_s  = 1'b1;
        m_valid_n = 1'b1;
        s_valid_n = 1'b0;
      end else if (accept) begin
        m_load_dec = 1'b1;
        m_valid_n  = 1'b1;
      end else begin
        m_valid_n = 1'b0;
      end
    end else if (accept) begin
      s_load    = 1'b1;
      s_valid_n = 1'b1;
    end
    if (flush) begin
      m_valid_n = 1'b0;
      s_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      s_valid    <= 1'b0;
      in_ready_q <= 1'b1;
      m_uop      <= '0;
      s_uop      <= '0;
    end else begin
      m_valid    <= m_valid_n;
      s_valid    <= s_valid_n;
      in_ready_q <= ~s_valid_n;
      if (m_load_s)
        m_uop <= s_uop;
      else if (m_load_dec)
        m_uop <= dec_uop;
      if (s_load)
        s_uop <= dec_uop;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid;
  assign out_uop   = m_uop;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: directed decode vectors, backpressure, flush
// and reset cases, then a random stream against a reference decoder.
module tb_instr_decode_stage;
  import rv32i_types::*;

  localparam int PC_W  = 32;
  localparam int UOP_W = $bits(decoded_uop_t);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready, out_valid;
  logic [31:0]     in_instr = '0;
  logic [PC_W-1:0] in_pc = '0;
  decoded_uop_t    out_uop;

  logic [UOP_W-1:0] cur_exp = '0;
  logic [UOP_W-1:0] exp_q[$];
  logic [UOP_W-1:0] prev_uop = '0;
  bit               prev_stall = 1'b0;
  int               checks = 0, failures = 0, cycle = 0, xfers = 0;
  bit               rand_bp = 1'b0, rand_flush = 1'b0;

  instr_decode_stage #(.PC_W(PC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_uop   (out_uop)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [UOP_W-1:0] mk(input logic [31:0] pc, input logic [6:0] op,
      input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm, input logic [3:0] alu, input logic [3:0] flags);
    decoded_uop_t u;
    u = '0;
    u.pc = pc; u.opcode = rv32i_opcode'(op); u.funct3 = f3;
    u.rd = rd; u.rs1 = rs1; u.rs2 = rs2; u.imm = imm; u.alu_op = alu_op_type'(alu);
    {u.uses_rs1, u.uses_rs2, u.writes_rd, u.illegal} = flags;
    return u;
  endfunction

  // Reference decoder built from the instruction-set rules with plain arithmetic.
  function automatic logic [UOP_W-1:0] model(input logic [31:0] i, input logic [31:0] pc);
    decoded_uop_t u;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [31:0] sgn, imm_i, imm_s, imm_b, imm_j;
    bit r1, r2, wd, bad;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    sgn = i[31] ? 32'hFFFF_FFFF : 32'h0;
    imm_i = (sgn << 12) | 32'(i[31:20]);
    imm_s = (sgn << 12) | (32'(i[31:25]) << 5) | 32'(i[11:7]);
    imm_b = (sgn << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
    imm_j = (sgn << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
    u = '0; r1 = 0; r2 = 0; wd = 0; bad = 0;
    u.pc = pc; u.opcode = rv32i_opcode'(op); u.funct3 = f3; u.alu_op = alu_op_add;
    case (op)
      7'h37, 7'h17: begin u.imm = i & 32'hFFFF_F000; wd = 1; end
      7'h6F: begin u.imm = imm_j; wd = 1; end
      7'h67: begin u.imm = imm_i; r1 = 1; wd = 1; bad = (f3 != 0); end
      7'h03: begin u.imm = imm_i; r1 = 1; wd = 1; bad = !(f3 inside {0, 1, 2, 4, 5}); end
      7'h23: begin u.imm = imm_s; r1 = 1; r2 = 1; bad = (f3 > 2); end
      7'h63: begin u.imm = imm_b; r1 = 1; r2 = 1; bad = (f3 inside {2, 3}); end
      7'h13: begin
        u.imm = imm_i; r1 = 1; wd = 1;
        u.alu_op = alu_op_type'({(f3 == 5) && f7[5], f3});
        if (f3 == 1) bad = (f7 != 0);
        if (f3 == 5) bad = !(f7 inside {0, 32});
      end
      7'h33: begin
        r1 = 1; r2 = 1; wd = 1;
        u.alu_op = alu_op_type'({f7[5], f3});
        bad = !((f7 == 0) || (f7 == 32 && (f3 inside {0, 5})));
      end
      default: bad = 1;
    endcase
    u.uses_rs1  = r1 && !bad;
    u.uses_rs2  = r2 && !bad;
    u.writes_rd = wd && !bad && (i[11:7] != 0);
    u.rs1 = u.uses_rs1 ? i[19:15] : 5'd0;
    u.rs2 = u.uses_rs2 ? i[24:20] : 5'd0;
    u.rd  = u.writes_rd ? i[11:7] : 5'd0;
    u.illegal = bad;
    return u;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;
      3: w[6:0] = 7'h67;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;
      6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;  8: w[6:0] = 7'h33;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] w, input logic [31:0] pc, input logic [UOP_W-1:0] e);
    bit acc;
    acc = 0;
    in_instr = w; in_pc = pc; cur_exp = e; in_valid = 1'b1;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; failures++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) check("hold_stable", out_uop, prev_uop);
      if (out_valid && out_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_uop: got %h expected none", out_uop);
        end else begin
          check("uop", out_uop, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_uop   = out_uop;
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    if (rand_flush) flush = ($urandom_range(0, 49) == 0);
  end

  // ---------------- main sequence ----------------
  logic [31:0]      d_instr[10];
  logic [UOP_W-1:0] d_exp[10];
  logic [31:0]      w0, w1, w2;
  int               c0, x0;

  initial begin
    d_instr[0] = 32'hFFF00293; d_exp[0] = mk(32'h1000, 7'h13, 0, 5, 0, 0, 32'hFFFF_FFFF, 4'h0, 4'b1010);
    d_instr[1] = 32'hFE208EE3; d_exp[1] = mk(32'h1004, 7'h63, 0, 0, 1, 2, 32'hFFFF_FFFC, 4'h0, 4'b1100);
    d_instr[2] = 32'h001000EF; d_exp[2] = mk(32'h1008, 7'h6F, 0, 1, 0, 0, 32'h0000_0800, 4'h0, 4'b0010);
    d_instr[3] = 32'h402081B3; d_exp[3] = mk(32'h100C, 7'h33, 0, 3, 1, 2, 32'h0, 4'h8, 4'b1110);
    d_instr[4] = 32'h4040D193; d_exp[4] = mk(32'h1010, 7'h13, 5, 3, 1, 0, 32'h0000_0404, 4'hD, 4'b1010);
    d_instr[5] = 32'h40409193; d_exp[5] = mk(32'h1014, 7'h13, 1, 0, 0, 0, 32'h0000_0404, 4'h1, 4'b0001);
    d_instr[6] = 32'h00208033; d_exp[6] = mk(32'h1018, 7'h33, 0, 0, 1, 2, 32'h0, 4'h0, 4'b1100);
    d_instr[7] = 32'h12345537; d_exp[7] = mk(32'h101C, 7'h37, 5, 10, 0, 0, 32'h1234_5000, 4'h0, 4'b0010);
    d_instr[8] = 32'h0020A423; d_exp[8] = mk(32'h1020, 7'h23, 2, 0, 1, 2, 32'h0000_0008, 4'h0, 4'b1100);
    d_instr[9] = 32'hFFFFFFFF; d_exp[9] = mk(32'h1024, 7'h7F, 7, 0, 0, 0, 32'h0, 4'h0, 4'b0001);

    // reset state
    idle(3);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_out_uop", out_uop, 128'd0);
    rst_n = 1'b1;
    idle(1);
    check("post_reset_out_valid", 128'(out_valid), 128'd0);
    check("post_reset_in_ready", 128'(in_ready), 128'd1);

    // one-cycle latency, then the directed decode vectors
    out_ready = 1'b1;
    send(d_instr[0], 32'h1000, d_exp[0]);
    check("latency_valid", 128'(out_valid), 128'd1);
    check("latency_uop", out_uop, d_exp[0]);
    for (int k = 1; k < 10; k++) send(d_instr[k], 32'h1000 + 32'(4 * k), d_exp[k]);
    wait_drain();

    // backpressure: two captured, third waits
    w0 = rand_instr(); w1 = rand_instr(); w2 = rand_instr();
    out_ready = 1'b0;
    send(w0, 32'h2000, model(w0, 32'h2000));
    send(w1, 32'h2004, model(w1, 32'h2004));
    check("bp_in_ready_low", 128'(in_ready), 128'd0);
    fork
      send(w2, 32'h2008, model(w2, 32'h2008));
      begin
        idle(3);
        check("bp_still_full", 128'(in_ready), 128'd0);
        check("bp_hold_first", out_uop, model(w0, 32'h2000));
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // flush with both entries full and in_valid high
    out_ready = 1'b0;
    send(w0, 32'h3000, model(w0, 32'h3000));
    send(w1, 32'h3004, model(w1, 32'h3004));
    in_instr = w2; in_valid = 1'b1; flush = 1'b1;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_full_out_valid", 128'(out_valid), 128'd0);
    check("flush_full_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1; x0 = xfers;
    idle(5);
    check("flush_full_nothing_out", 128'(xfers - x0), 128'd0);

    // flush with M full, an accept and a drain in the same cycle
    out_ready = 1'b0;
    send(w0, 32'h3100, model(w0, 32'h3100));
    in_instr = w1; cur_exp = model(w1, 32'h3104); in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    x0 = xfers;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_accept_out_valid", 128'(out_valid), 128'd0);
    check("flush_drain_counted", 128'(xfers - x0), 128'd1);
    x0 = xfers;
    idle(5);
    check("flush_accept_nothing_out", 128'(xfers - x0), 128'd0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(w0, 32'h4000, model(w0, 32'h4000));
    send(w1, 32'h4004, model(w1, 32'h4004));
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 128'(out_valid), 128'd0);
    check("midreset_in_ready", 128'(in_ready), 128'd1);
    check("midreset_out_uop", out_uop, 128'd0);
    idle(1);
    rst_n = 1'b1; out_ready = 1'b1; x0 = xfers;
    idle(4);
    check("midreset_nothing_out", 128'(xfers - x0), 128'd0);

    // full throughput with out_ready held high
    c0 = cycle; x0 = xfers;
    for (int k = 0; k < 20; k++) begin
      w0 = rand_instr();
      send(w0, 32'h5000 + 32'(4 * k), model(w0, 32'h5000 + 32'(4 * k)));
    end
    check("tput_accept_cycles", 128'(cycle - c0), 128'd20);
    idle(1);
    check("tput_emitted", 128'(xfers - x0), 128'd20);
    wait_drain();

    // random stream with random backpressure and occasional flush
    rand_bp = 1'b1; rand_flush = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      w0 = rand_instr();
      send(w0, 32'h8000 + 32'(4 * k), model(w0, 32'h8000 + 32'(4 * k)));
    end
    rand_bp = 1'b0; rand_flush = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered RV32I decode stage between the fetch/instruction queue and rename/dispatch in mp_ooo. Accepts one raw 32-bit instruction word plus PC per cycle over a valid/ready handshake. Emits one fully decoded micro-op: register indices, format-correct sign-extended immediate, ALU operation and legality flag. A two-entry skid buffer gives a registered `in_ready` and full throughput under backpressure.

## Interface
- `PC_W`, default 32: PC width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `flush` input 1: discard all buffered micro-ops (branch mispredict recovery).
- `in_valid` input 1: instruction presented.
- `in_ready` output 1: stage can accept; driven directly from a register.
- `in_instr` input 32: raw instruction word, interpreted as `instr_t`.
- `in_pc` input PC_W: PC of `in_instr`.
- `out_valid` output 1: `out_uop` valid.
- `out_ready` input 1: downstream accepts.
- `out_uop` output `$bits(decoded_uop_t)`: decoded micro-op.

## Operation
- `decoded_uop_t` fields:
  - `pc`, `opcode` (`rv32i_opcode`), `funct3`, `rd`, `rs1`, `rs2`, `imm[31:0]`, `alu_op` (`alu_op_type`).
  - Flags: `uses_rs1`, `uses_rs2`, `writes_rd`, `illegal`.
- Immediates:
  - I: sext(i[31:20]).
  - S: sext({i[31:25], i[11:7]}).
  - B: sext({i[31], i[7], i[30:25], i[11:8], 0}).
  - U: {i[31:12], 12'b0}.
  - J: sext({i[31], i[19:12], i[20], i[30:21], 0}).
  - R-type: imm = 0.
- Register usage:
  - `uses_rs1`: jalr, br, load, store, imm, reg.
  - `uses_rs2`: br, store, reg.
  - `writes_rd`: lui, auipc, jal, jalr, load, imm, reg, and only when rd != 0.
  - When a flag is clear, the corresponding index field is forced to 0.
- `alu_op`:
  - reg: {funct7[5], funct3}.
  - imm: {funct3==sr ? funct7[5] : 0, funct3}.
  - lui, auipc, jal, jalr, load, store, br: `alu_op_add`.
- `illegal` is set for:
  - an unknown opcode or i[1:0] != 2'b11.
  - jalr with funct3 != 000.
  - load with funct3 ∉ {000, 001, 010, 100, 101}.
  - store with funct3 ∉ {000, 001, 010}.
  - br with funct3 ∈ {010, 011}.
  - reg with funct7 ∉ {base, variant}, or funct7=variant with funct3 ∉ {add, sr}.
  - imm shift (sll/sr) with funct7 not a legal value. sll requires base. sr requires base or variant.
- Illegal uops: all use/write flags are cleared. `pc` and the raw fields still pass. The uop still flows; it is not dropped.
- Buffer: main register M (drives outputs) plus skid register S.
  - Accept when `in_valid && in_ready`.
  - Accepted data goes to M if M is empty or draining this cycle; otherwise it goes to S.
  - When M drains and S is valid, S moves to M.
  - `in_ready` is registered and equals !S.valid.
  - Order is strictly preserved.
- Flush has priority over everything:
  - M.valid and S.valid are cleared next cycle.
  - Any input accepted in the flush cycle is discarded.
  - The `out_ready` handshake in the flush cycle still counts as a transfer.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on `out_uop` after edge N, when M was empty.
- Throughput is 1 uop/cycle while `out_ready` stays high.
- `out_uop` is stable while `out_valid && !out_ready`.
- `out_valid` does not depend combinationally on `out_ready`.
- Reset (async assert, sync deassert use):
  - `out_valid` = 0, `in_ready` = 1.
  - M and S contents = 0; `out_uop` = 0.
- Reset mid-stream drops both entries immediately.
- Both entries full: `in_ready` = 0 the cycle after S fills, and returns to 1 the cycle after M drains.
- When S is full, simultaneous drain and accept is impossible, since `in_ready` = 0.
- When M alone is full, simultaneous drain and accept keeps M full with the new uop and S empty.

## Structure
- Add `decoded_uop_t` to `rv32i_types` next to `instr_t` and `alu_op_type`.
- Also add an `imm_fmt_t` enum (I, S, B, U, J, R) to `rv32i_types`.
- Add a B-type immediate helper function to `rv32i_types`, since `b_type` carries split fields only.
- Sub-module `rv32i_decode_comb`: purely combinational, `instr_t` + pc → `decoded_uop_t`. The stage instantiates it once on the input side and registers its result.

## Test plan
- Reset → `out_valid` = 0, `in_ready` = 1, `out_uop` = 0. Assert `rst_n` low mid-stream → both entries are gone the same cycle.
- `addi x5,x0,-1` (0xFFF00293) → imm = 0xFFFFFFFF, rd = 5, rs1 = 0, `uses_rs1` = 1, `writes_rd` = 1, alu_op = add, 1 cycle later.
- Immediate formats:
  - `beq x1,x2,-4` (0xFE208EE3) → imm = 0xFFFFFFFC, `uses_rs2` = 1, `writes_rd` = 0.
  - `jal x1,+2048` (0x001000EF) → imm = 0x00000800.
- Decode corner cases:
  - `sub x3,x1,x2` (0x402081B3) → alu_op_sub.
  - `srai x3,x1,4` (0x4040D193) → alu_op_sra.
  - `slli` with funct7=variant (0x40409193) → illegal = 1, all flags = 0.
  - `add x0,x1,x2` → `writes_rd` = 0.
- Backpressure and flush:
  - Hold `out_ready` = 0 and stream 3 words → 2 captured, `in_ready` drops to 0. Release → emitted in order, no loss or duplication.
  - `flush` with both entries full plus an input accepted in the same cycle → `out_valid` = 0 next cycle, nothing emerges.
- Random stream with random `out_ready` → output sequence equals the reference-decoded input sequence, with 1 uop/cycle when `out_ready` = 1.
